pipe_perf_monitor: RTL

Synthesizable, parametrised event-counting unit for the pipelined CPU. It gives hardware stall/flush/retire accounting and a cycle-bounded run window. It sits beside the CPU top level, takes one-bit event strobes from the hazard and flush logic, and exposes snapshotted counts through a registered read port. The bench and debug logic read this block instead of counting events themselves.

---
 rtl/pipe_perf_monitor.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: per-channel pipeline event counters (stall/flush/retire)
// with a cycle-bounded run window, a snapshot shadow bank and a registered
// read port. Live counters only advance in RUN; shadows load on snap_i and
// are read with one cycle of latency.
module pipe_perf_monitor #(
  parameter int NUM_EVT  = 4,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1,
  parameter int SEL_W    = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] evt_mask_i,
  input  logic               limit_en_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT-1:0] ovf_o,
  output logic               snap_valid_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Next value of a counter: all-ones either sticks or wraps to zero.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] val);
    if ((SATURATE != 0) && (&val)) begin
      return val;
    end else begin
      return val + CNT_W'(1);
    end
  endfunction

  // An increment attempted at all-ones is an overflow in both modes.
  function automatic logic cnt_at_max(input logic [CNT_W-1:0] val);
    return &val;
  endfunction

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [CNT_W-1:0]   cycle_r;
  logic [CNT_W-1:0]   cycle_nxt_s;
  logic [CNT_W-1:0]   limit_r;
  logic [CNT_W-1:0]   limit_nxt_s;
  logic [CNT_W-1:0]   cnt_r     [NUM_EVT];
  logic [CNT_W-1:0]   cnt_nxt_s [NUM_EVT];
  logic [NUM_EVT-1:0] ovf_r;
  logic [NUM_EVT-1:0] ovf_nxt_s;
  logic [CNT_W-1:0]   shadow_r  [NUM_EVT+1];
  logic               snap_valid_r;
  logic [CNT_W-1:0]   rd_mux_s;
  logic [CNT_W-1:0]   rd_data_r;

  // Next-state and counter-update logic; clear_i overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    cycle_nxt_s = cycle_r;
    limit_nxt_s = limit_r;
    ovf_nxt_s   = ovf_r;
    for (int k = 0; k < NUM_EVT; k++) begin
      cnt_nxt_s[k] = cnt_r[k];
    end
    if (clear_i) begin
      state_nxt_s = ST_IDLE;
      cycle_nxt_s = {CNT_W{1'b0}};
      limit_nxt_s = {CNT_W{1'b0}};
      ovf_nxt_s   = {NUM_EVT{1'b0}};
      for (int k = 0; k < NUM_EVT; k++) begin
        cnt_nxt_s[k] = {CNT_W{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            limit_nxt_s = limit_i;
            // A zero-length bounded run finishes without counting a cycle.
            if (limit_en_i && (limit_i == {CNT_W{1'b0}})) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          cycle_nxt_s = cnt_next(cycle_r);
          for (int k = 0; k < NUM_EVT; k++) begin
            if (evt_i[k] && evt_mask_i[k]) begin
              cnt_nxt_s[k] = cnt_next(cnt_r[k]);
              ovf_nxt_s[k] = ovf_r[k] | cnt_at_max(cnt_r[k]);
            end else begin
              cnt_nxt_s[k] = cnt_r[k];
              ovf_nxt_s[k] = ovf_r[k];
            end
          end
          // Limit compares against the post-increment count, so this
          // cycle's events are still counted before stopping.
          if (limit_en_i && (cycle_nxt_s == limit_r)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, live counters, limit and sticky overflow flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      cycle_r <= {CNT_W{1'b0}};
      limit_r <= {CNT_W{1'b0}};
      ovf_r   <= {NUM_EVT{1'b0}};
      for (int k = 0; k < NUM_EVT; k++) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      cycle_r <= cycle_nxt_s;
      limit_r <= limit_nxt_s;
      ovf_r   <= ovf_nxt_s;
      for (int k = 0; k < NUM_EVT; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
      end
    end
  end

  // Shadow bank captures live values as they stand before this edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_valid_r <= 1'b0;
      for (int k = 0; k <= NUM_EVT; k++) begin
        shadow_r[k] <= {CNT_W{1'b0}};
      end
    end else if (clear_i) begin
      snap_valid_r <= 1'b0;
      for (int k = 0; k <= NUM_EVT; k++) begin
        shadow_r[k] <= {CNT_W{1'b0}};
      end
    end else if (snap_i) begin
      snap_valid_r <= 1'b1;
      for (int k = 0; k < NUM_EVT; k++) begin
        shadow_r[k] <= cnt_r[k];
      end
      shadow_r[NUM_EVT] <= cycle_r;
    end else begin
      snap_valid_r <= snap_valid_r;
    end
  end

  // Read mux: event shadows, then cycle shadow at NUM_EVT, zero above.
  always_comb begin
    rd_mux_s = {CNT_W{1'b0}};
    for (int i = 0; i <= NUM_EVT; i++) begin
      rd_mux_s = (rd_sel_i == SEL_W'(i)) ? shadow_r[i] : rd_mux_s;
    end
  end

  // Registered read port; a same-edge snap is seen one cycle later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_r <= {CNT_W{1'b0}};
    end else begin
      rd_data_r <= rd_mux_s;
    end
  end

  assign rd_data_o    = rd_data_r;
  assign cycle_o      = cycle_r;
  assign running_o    = (state_r == ST_RUN);
  assign done_o       = (state_r == ST_DONE);
  assign ovf_o        = ovf_r;
  assign snap_valid_o = snap_valid_r;

endmodule
